// File: rtl/byte_stream_injector.sv
// Byte stream injector: waits for code-RAM init, streams a payload (buffer,
// incrementing or LFSR bytes) over a valid/ready port, appends a terminator,
// then waits for compressor completion before pulsing done.
module byte_stream_injector #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       AW        = 6,
    parameter logic [DATA_W-1:0] EOF_CODE  = DATA_W'(8'h0D),
    parameter int unsigned       PRE_WAIT  = 10,
    parameter int unsigned       POST_WAIT = 20,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(8'hB8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic [AW:0]       len,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic              init_done,
    input  logic              lzw_done,
    input  logic              final_done,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AW:0]       byte_cnt
);

    localparam int unsigned MAX_WAIT  = (PRE_WAIT > POST_WAIT) ? PRE_WAIT : POST_WAIT;
    localparam int unsigned CNT_W     = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_WAIT - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_WAIT - 1);
    localparam logic [AW:0]      MAX_LEN   = (AW+1)'(2 ** AW);
    localparam logic [1:0]       MODE_BUF  = 2'd0;
    localparam logic [1:0]       MODE_LFSR = 2'd2;

    typedef enum logic [2:0] {
        StIdle, StWaitInit, StPre, StSend, StEof, StWaitDone, StPost, StFin
    } state_e;

    state_e              r_state, w_state_d;
    logic [DATA_W-1:0]   r_buf [2**AW];
    logic [AW:0]         r_len;
    logic [1:0]          r_mode;
    logic [DATA_W-1:0]   r_val;
    logic [AW:0]         r_byte_cnt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_lzw, r_fin, r_err;
    logic                w_start_ok, w_start_bad, w_hs, w_last, w_track;
    logic [DATA_W-1:0]   w_val_next, w_tx_data;
    logic                w_tx_valid;

    assign w_start_ok  = start && (r_state == StIdle) && (len <= MAX_LEN);
    assign w_start_bad = start && (r_state == StIdle) && (len > MAX_LEN);
    assign w_hs        = w_tx_valid && tx_ready;
    assign w_last      = (r_byte_cnt + (AW+1)'(1)) == r_len;
    // Completion flags are only collected once the packet is under way.
    assign w_track     = (r_state == StPre) || (r_state == StSend) || (r_state == StEof) ||
                         (r_state == StWaitDone) || (r_state == StPost);
    // Mode 1 increments; mode 2 is a Galois LFSR shift.
    assign w_val_next  = (r_mode == MODE_LFSR) ?
                         ({1'b0, r_val[DATA_W-1:1]} ^ (r_val[0] ? LFSR_TAPS : '0)) :
                         r_val + DATA_W'(1);

    assign tx_data  = w_tx_data;
    assign tx_valid = w_tx_valid;
    assign busy     = (r_state != StIdle);
    assign done     = (r_state == StFin);
    assign err      = r_err;
    assign byte_cnt = r_byte_cnt;

    // Payload buffer: loadable only while idle, deliberately not reset.
    always_ff @(posedge clk) begin
        if (load_we && (r_state == StIdle)) begin
            r_buf[load_addr] <= load_data;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state decode and transmit outputs.
    always_comb begin
        w_state_d  = r_state;
        w_tx_valid = 1'b0;
        w_tx_data  = '0;
        case (r_state)
            StIdle:     if (w_start_ok) w_state_d = StWaitInit;
            StWaitInit: if (init_done) w_state_d = StPre;
            StPre: begin
                if (r_cnt == PRE_LAST) w_state_d = (r_len == '0) ? StEof : StSend;
            end
            StSend: begin
                w_tx_valid = 1'b1;
                w_tx_data  = (r_mode == MODE_BUF) ? r_buf[r_byte_cnt[AW-1:0]] : r_val;
                if (w_hs && w_last) w_state_d = StEof;
            end
            StEof: begin
                w_tx_valid = 1'b1;
                w_tx_data  = EOF_CODE;
                if (w_hs) w_state_d = StWaitDone;
            end
            // A flag rising this cycle counts as set.
            StWaitDone: if ((r_lzw || lzw_done) && (r_fin || final_done)) w_state_d = StPost;
            StPost:     if (r_cnt == POST_LAST) w_state_d = StFin;
            StFin:      w_state_d = StIdle;
            default:    w_state_d = StIdle;
        endcase
    end

    // Datapath: launch latching, wait counters, byte generator, sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len      <= '0;
            r_mode     <= '0;
            r_val      <= '0;
            r_byte_cnt <= '0;
            r_cnt      <= '0;
            r_lzw      <= 1'b0;
            r_fin      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_start_bad;
            case (r_state)
                StIdle: begin
                    if (w_start_ok) begin
                        r_len      <= len;
                        r_mode     <= (mode == 2'd3) ? MODE_BUF : mode;
                        // An all-zero LFSR would lock up.
                        r_val      <= ((mode == MODE_LFSR) && (seed == '0)) ? DATA_W'(1) : seed;
                        r_byte_cnt <= '0;
                        r_cnt      <= '0;
                        r_lzw      <= 1'b0;
                        r_fin      <= 1'b0;
                    end
                end
                StPre:  r_cnt <= (r_cnt == PRE_LAST) ? '0 : r_cnt + CNT_W'(1);
                StSend: begin
                    if (w_hs) begin
                        r_byte_cnt <= r_byte_cnt + (AW+1)'(1);
                        r_val      <= w_val_next;
                    end
                end
                StPost: r_cnt <= r_cnt + CNT_W'(1);
                default: ;
            endcase
            if (w_track) begin
                if (lzw_done) r_lzw <= 1'b1;
                if (final_done) r_fin <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_byte_stream_injector.sv
// Self-checking bench for byte_stream_injector with a queue-based reference model.
module tb_byte_stream_injector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_we = 1'b0;
    logic [5:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       start = 1'b0;
    logic [6:0] len = '0;
    logic [1:0] mode = '0;
    logic [7:0] seed = '0;
    logic       init_done = 1'b0, lzw_done = 1'b0, final_done = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       busy, done, err;
    logic [6:0] byte_cnt;

    byte_stream_injector dut (
        .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .start(start), .len(len), .mode(mode), .seed(seed), .init_done(init_done),
        .lzw_done(lzw_done), .final_done(final_done), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done), .err(err), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem_model [64];
    logic [7:0] exp_q [$];
    logic [7:0] got [$];
    bit         stable_ok, timed_out, busy_drop, final_busy;
    int         done_pulses, err_seen, pre_gap, post_gap;
    logic [6:0] cnt_at_done;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected wire bytes: payload by mode rules, then the terminator.
    task automatic build_exp(input int m, input logic [7:0] sd, input int ln);
        logic [7:0] v;
        int mm;
        exp_q.delete();
        mm = (m == 3) ? 0 : m;
        v = (mm == 2 && sd == 8'h00) ? 8'h01 : sd;
        for (int i = 0; i < ln; i++) begin
            if (mm == 0) exp_q.push_back(mem_model[i]);
            else if (mm == 1) exp_q.push_back(8'((int'(sd) + i) % 256));
            else begin
                exp_q.push_back(v);
                v = (v / 2) ^ ((v % 2 == 1) ? 8'hB8 : 8'h00);
            end
        end
        exp_q.push_back(8'h0D);
    endtask

    function automatic int payload_diffs();
        int d = 0;
        if (got.size() != exp_q.size()) return 1000;
        for (int i = 0; i < got.size(); i++) if (got[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic load_buffer(input int addr, input logic [7:0] data);
        load_we = 1'b1; load_addr = 6'(addr); load_data = data;
        step();
        load_we = 1'b0;
        mem_model[addr] = data;
    endtask

    // Runs one packet, recording every handshake and the timing landmarks.
    // bp: 0 ready always, 1 toggling, 2 random. late: final_done raised after the terminator.
    task automatic run_packet(input int m, input logic [7:0] sd, input int ln,
                              input int bp, input bit late);
        int hs = 0, eof_cyc = -1, both_cyc = -1, done_cyc = -1, first_valid = -1;
        bit prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        got.delete();
        stable_ok = 1'b1; timed_out = 1'b0; busy_drop = 1'b0;
        done_pulses = 0; err_seen = 0; cnt_at_done = '1;
        lzw_done = 1'b1; final_done = !late;
        start = 1'b1; len = 7'(ln); mode = 2'(m); seed = sd;
        step();
        start = 1'b0;
        for (int n = 0; n < 600; n++) begin
            // Writes and a start while busy must both be ignored.
            load_we = (n < 2); load_addr = 6'(n); load_data = 8'($urandom);
            init_done = (n >= 2);
            start = (n == 5);
            if (n == 5) len = 7'd70;
            if (late && eof_cyc >= 0 && n == eof_cyc + 3) begin
                final_done = 1'b1; both_cyc = n;
            end
            if (bp == 0) tx_ready = 1'b1;
            else if (bp == 1) tx_ready = 1'(n);
            else tx_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!busy && done_cyc < 0) busy_drop = 1'b1;
            if (err) err_seen++;
            if (prev_stall && (!tx_valid || tx_data !== prev_data)) stable_ok = 1'b0;
            if (tx_valid && first_valid < 0) first_valid = n;
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                hs++;
                if (hs == ln + 1) eof_cyc = n;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data = tx_data;
            if (done) begin
                done_pulses++;
                if (done_cyc < 0) begin done_cyc = n; cnt_at_done = byte_cnt; end
            end
            step();
            if (done_cyc >= 0 && n >= done_cyc + 2) break;
        end
        timed_out = (done_cyc < 0);
        final_busy = busy;
        pre_gap = first_valid - 2 - 1;
        post_gap = late ? done_cyc - both_cyc - 1 : -1;
        load_we = 1'b0; start = 1'b0; init_done = 1'b0;
        lzw_done = 1'b0; final_done = 1'b0; tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            failures++; $display("FAIL reset_tx: valid=%b data=%h want 0/00", tx_valid, tx_data);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || byte_cnt !== 7'd0) begin
            failures++;
            $display("FAIL reset_status: busy=%b done=%b err=%b cnt=%0d want all 0",
                     busy, done, err, byte_cnt);
        end
    endtask

    task automatic test_basic();
        build_exp(0, 8'h00, 20);
        run_packet(0, 8'h00, 20, 0, 1'b1);
        checks++;
        if (timed_out) begin failures++; $display("FAIL basic_timeout: no done seen"); end
        checks++;
        if (payload_diffs() != 0) begin
            failures++;
            $display("FAIL basic_bytes: got %0d bytes (first %h), want %0d bytes (first %h)",
                     got.size(), (got.size() > 0) ? got[0] : 8'hxx, exp_q.size(), exp_q[0]);
        end
        checks++;
        if (pre_gap != 10) begin failures++; $display("FAIL basic_pre_gap: got %0d want 10", pre_gap); end
        checks++;
        if (post_gap != 20) begin failures++; $display("FAIL basic_post_gap: got %0d want 20", post_gap); end
        checks++;
        if (done_pulses != 1) begin failures++; $display("FAIL basic_done_pulses: got %0d want 1", done_pulses); end
        checks++;
        if (cnt_at_done !== 7'd20) begin failures++; $display("FAIL basic_byte_cnt: got %0d want 20", cnt_at_done); end
        checks++;
        if (err_seen != 0 || busy_drop || final_busy) begin
            failures++;
            $display("FAIL basic_status: err=%0d busy_drop=%b busy_after=%b want 0/0/0",
                     err_seen, busy_drop, final_busy);
        end
    endtask

    task automatic test_back_pressure();
        build_exp(0, 8'h00, 20);
        run_packet(0, 8'h00, 20, 1, 1'b0);
        checks++;
        if (payload_diffs() != 0) begin
            failures++; $display("FAIL bp_bytes: %0d positions differ", payload_diffs());
        end
        checks++;
        if (!stable_ok) begin failures++; $display("FAIL bp_stable: tx_data/valid changed while stalled, want stable"); end
        checks++;
        if (done_pulses != 1 || cnt_at_done !== 7'd20) begin
            failures++; $display("FAIL bp_done: pulses=%0d cnt=%0d want 1/20", done_pulses, cnt_at_done);
        end
    endtask

    task automatic test_empty();
        build_exp(0, 8'h00, 0);
        run_packet(0, 8'h00, 0, 0, 1'b0);
        checks++;
        if (got.size() != 1 || got[0] !== 8'h0D) begin
            failures++; $display("FAIL empty_bytes: got %0d bytes, want only 0D", got.size());
        end
        checks++;
        if (cnt_at_done !== 7'd0 || done_pulses != 1) begin
            failures++; $display("FAIL empty_done: cnt=%0d pulses=%0d want 0/1", cnt_at_done, done_pulses);
        end
    endtask

    task automatic test_rejected();
        int errs = 0, busys = 0;
        start = 1'b1; len = 7'd65; mode = 2'd0; seed = 8'h00;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (err) errs++;
            if (busy) busys++;
            step();
        end
        checks++;
        if (errs != 1) begin failures++; $display("FAIL reject_err: pulses=%0d want 1", errs); end
        checks++;
        if (busys != 0) begin failures++; $display("FAIL reject_busy: busy cycles=%0d want 0", busys); end
        build_exp(0, 8'h00, 64);
        run_packet(0, 8'h00, 64, 2, 1'b0);
        checks++;
        if (payload_diffs() != 0 || !stable_ok) begin
            failures++;
            $display("FAIL full_len_bytes: got %0d bytes stable=%b, want 65 stable", got.size(), stable_ok);
        end
        checks++;
        if (cnt_at_done !== 7'd64) begin failures++; $display("FAIL full_len_cnt: got %0d want 64", cnt_at_done); end
    endtask

    task automatic test_modes();
        logic [7:0] lfsr_ref [4];
        logic [7:0] inc_ref [4];
        int bad;
        lfsr_ref = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
        inc_ref  = '{8'hFE, 8'hFF, 8'h00, 8'h0D};
        build_exp(2, 8'h00, 12);
        run_packet(2, 8'h00, 12, 0, 1'b0);
        bad = 0;
        for (int i = 0; i < 4; i++) if (got.size() <= i || got[i] !== lfsr_ref[i]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL lfsr_prefix: %0d of 4 wrong, want 01 B8 5C 2E", bad); end
        checks++;
        if (payload_diffs() != 0) begin failures++; $display("FAIL lfsr_bytes: %0d differ", payload_diffs()); end
        run_packet(1, 8'hFE, 3, 0, 1'b0);
        bad = (got.size() != 4) ? 1 : 0;
        for (int i = 0; i < 4; i++) if (got.size() <= i || got[i] !== inc_ref[i]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL inc_wrap: %0d wrong, want FE FF 00 0D", bad); end
        build_exp(3, 8'h77, 9);
        run_packet(3, 8'h77, 9, 0, 1'b0);
        checks++;
        if (payload_diffs() != 0) begin failures++; $display("FAIL mode3_as_buf: %0d differ", payload_diffs()); end
    endtask

    task automatic test_eof_in_payload();
        load_buffer(2, 8'h0D);
        build_exp(0, 8'h00, 5);
        run_packet(0, 8'h00, 5, 0, 1'b0);
        checks++;
        if (payload_diffs() != 0 || cnt_at_done !== 7'd5) begin
            failures++; $display("FAIL eof_payload: bytes=%0d cnt=%0d want 6/5", got.size(), cnt_at_done);
        end
    endtask

    task automatic test_random();
        int m, ln, bp;
        logic [7:0] sd;
        for (int k = 0; k < 5; k++) begin
            m = $urandom_range(0, 3); ln = $urandom_range(0, 64);
            bp = $urandom_range(1, 2); sd = 8'($urandom);
            build_exp(m, sd, ln);
            run_packet(m, sd, ln, bp, 1'($urandom_range(0, 1)));
            checks++;
            if (payload_diffs() != 0 || !stable_ok || done_pulses != 1 || cnt_at_done !== 7'(ln)) begin
                failures++;
                $display("FAIL random_%0d: mode=%0d len=%0d bytes=%0d stable=%b pulses=%0d cnt=%0d",
                         k, m, ln, got.size(), stable_ok, done_pulses, cnt_at_done);
            end
        end
    endtask

    task automatic test_reset_mid();
        int hs = 0;
        bit hit = 1'b0;
        lzw_done = 1'b1; final_done = 1'b1; tx_ready = 1'b1;
        start = 1'b1; len = 7'd20; mode = 2'd0; seed = 8'h00;
        step();
        start = 1'b0; init_done = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (tx_valid && hs == 4) begin
                rst = 1'b0;
                #1;
                hit = 1'b1;
                break;
            end
            if (tx_valid && tx_ready) hs++;
            step();
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL midreset_reach: byte 5 never presented"); end
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || byte_cnt !== 7'd0) begin
            failures++;
            $display("FAIL midreset_outputs: valid=%b busy=%b cnt=%0d want 0/0/0", tx_valid, busy, byte_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b1; init_done = 1'b0; lzw_done = 1'b0; final_done = 1'b0; tx_ready = 1'b0;
        step();
        build_exp(0, 8'h00, 20);
        run_packet(0, 8'h00, 20, 0, 1'b0);
        checks++;
        if (payload_diffs() != 0) begin
            failures++; $display("FAIL midreset_replay: %0d differ after restart", payload_diffs());
        end
    endtask

    initial begin
        logic [7:0] basic_bytes [20];
        basic_bytes = '{8'h63, 8'h31, 8'h38, 8'h32, 8'h38, 8'h32, 8'h30, 8'h30, 8'h30, 8'h31,
                        8'h33, 8'h65, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h30, 8'h30};
        #12;
        test_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        for (int i = 0; i < 64; i++) begin
            if (i < 20) load_buffer(i, basic_bytes[i]);
            else load_buffer(i, 8'($urandom));
        end
        test_basic();
        test_back_pressure();
        test_empty();
        test_rejected();
        test_modes();
        test_eof_in_payload();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte_stream_injector.md
BYTE_STREAM_INJECTOR -- requirements
Module: byte_stream_injector

Interface
REQ-001 SHALL have parameter DATA_W, default 8, byte width of the stream.
REQ-002 SHALL have parameter AW, default 6; buffer depth is 2^AW entries.
REQ-003 SHALL have parameter EOF_CODE, default 8'h0D, the terminator sent after the payload.
REQ-004 SHALL have parameter PRE_WAIT, default 10, idle cycles between init_done and the first byte.
REQ-005 SHALL have parameter POST_WAIT, default 20, cycles between completion and the done pulse.
REQ-006 SHALL have parameter LFSR_TAPS, default 8'hB8, Galois feedback mask for mode 2.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have the following data input ports:
- load_we, input, 1 bit: buffer write enable.
- load_addr, input, AW bits: buffer write address.
- load_data, input, DATA_W bits: buffer write data.
REQ-010 SHALL have the following control input ports:
- start, input, 1 bit: one-cycle launch request.
- len, input, AW+1 bits: payload byte count, 0..2^AW.
- mode, input, 2 bits: 0 buffer, 1 incrementing, 2 LFSR, 3 treated as 0.
- seed, input, DATA_W bits: first value for modes 1 and 2.
REQ-011 SHALL have ports init_done, lzw_done and final_done, input, 1 bit each: level status from code-RAM init and the compressor.
REQ-012 SHALL have the transmit ports tx_data (output, DATA_W bits), tx_valid (output, 1 bit) and tx_ready (input, 1 bit), forming a valid/ready byte handshake to the serial model.
REQ-013 SHALL have the following status output ports:
- busy, output, 1 bit.
- done, output, 1 bit: one-cycle completion pulse.
- err, output, 1 bit: one-cycle pulse on a rejected start.
- byte_cnt, output, AW+1 bits: payload bytes accepted so far.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT_INIT, PRE, SEND, EOF, WAIT_DONE, POST and FIN.
REQ-015 IDLE: a start with len <= 2^AW SHALL latch len, mode and seed, clear byte_cnt and the done flags, and go to WAIT_INIT; a start with len > 2^AW SHALL pulse err and remain in IDLE.
REQ-016 WAIT_INIT SHALL leave for PRE on the first cycle init_done is high (level-sensitive).
REQ-017 PRE SHALL count exactly PRE_WAIT cycles, then go to SEND, or directly to EOF when len = 0.
REQ-018 SEND SHALL hold tx_valid high; tx_data SHALL stay stable until the cycle tx_valid and tx_ready are both high.
REQ-019 On each SEND handshake, byte_cnt SHALL increment and the next byte SHALL be presented on the following cycle with no bubble.
REQ-020 After the len-th handshake, SEND SHALL go to EOF.
REQ-021 Byte generation per mode:
- mode 0 SHALL send buffer[0..len-1].
- mode 1 SHALL send seed, seed+1, ..., wrapping modulo 2^DATA_W.
- mode 2 SHALL send seed, then each next value = (v>>1) XOR (LFSR_TAPS if v[0]).
- in mode 2, seed 0 SHALL be replaced by 1.
REQ-022 EOF SHALL present EOF_CODE with tx_valid high and go to WAIT_DONE on handshake; byte_cnt SHALL NOT count the terminator.
REQ-023 SHALL keep sticky flags for lzw_done and final_done, set from PRE onward.
REQ-024 WAIT_DONE SHALL advance to POST when both sticky flags are set, in any order, including when both are already set on entry.
REQ-025 POST SHALL count POST_WAIT cycles, then go to FIN.
REQ-026 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 busy SHALL be high in every state except IDLE.
REQ-028 start while busy SHALL be ignored with no err pulse.
REQ-029 load_we SHALL write the buffer only in IDLE; writes in any other state SHALL be discarded.
REQ-030 tx_valid SHALL NOT drop before its handshake.
REQ-031 Payload bytes equal to EOF_CODE SHALL be sent unmodified.

Reset
REQ-032 rst low SHALL asynchronously force:
- state IDLE.
- tx_valid=0, tx_data=0.
- busy=0, done=0, err=0.
- byte_cnt=0.
- all counters and sticky flags cleared.
REQ-033 Buffer contents SHALL NOT be cleared by reset.
REQ-034 Reset mid-stream SHALL abandon the packet immediately, with no terminator sent.

Verification
REQ-035 Scenario "basic packet":
- stimulus: load 63 31 38 32 38 32 30 30 30 31 33 65 30 30 30 30 30 31 30 30; mode 0, len 20; init_done high; tx_ready always high.
- response: after exactly 10 idle cycles, the 20 bytes then 0D on consecutive cycles; byte_cnt=20; done one cycle, 20 cycles after lzw_done and final_done are both high.
REQ-036 Scenario "back-pressure": as REQ-035 with tx_ready toggling 1-0-1-0 -> identical byte sequence, with tx_data stable while tx_ready is 0.
REQ-037 Scenario "empty packet": len 0 -> only 0D sent; byte_cnt=0.
REQ-038 Scenario "rejected start": len 65 with AW=6 -> err pulses once, busy stays 0; a later start with len 64 sends 64 bytes then 0D.
REQ-039 Scenario "generated modes":
- mode 2, seed 00: sequence 01 B8 5C 2E ...
- mode 1, seed FE, len 3: FE FF 00 then 0D.
REQ-040 Scenario "reset mid-stream": rst low during byte 5 -> tx_valid=0 and busy=0 immediately; a subsequent start reproduces the full packet from byte 0.
